fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one 8-bit, 64-entry FIFO write port among NUM_REQ producers. Grants one producer at a time for a burst of up to MAX_BURST beats, or until the producer marks the last beat. Beats go to the FIFO through a registered write stage. Uses the FIFO's full flag and occupancy count to throttle ahead of overflow.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 8, data width per beat
DEPTH, 64, FIFO capacity in entries
CNT_W, 8, width of fifo_count
MAX_BURST, 8, max beats per grant (1..255)
MARGIN, 4, headroom entries; beats are accepted only while fifo_count <= DEPTH-MARGIN

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  producer i has a beat
req_data  input  NUM_REQ*DATA_W  producer i data, slice [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  beat is last of producer i's packet
req_ready  output  NUM_REQ  beat accepted this cycle when valid&ready; only granted bit may be 1
fifo_full  input  1  FIFO full flag
fifo_count  input  CNT_W  FIFO occupancy
fifo_wr_en  output  1  registered write strobe to FIFO
fifo_din  output  DATA_W  registered write data to FIFO
grant_valid  output  1  a burst grant is active
grant_id  output  $clog2(NUM_REQ)  index of granted producer

Behaviour:
- Reset (async, immediate): state=IDLE; rr_ptr=NUM_REQ-1 (producer 0 has first priority); beat_cnt=0; req_ready=0; fifo_wr_en=0; fifo_din=0; grant_valid=0; grant_id=0. Reset mid-burst discards the burst. An un-issued registered beat is lost and is not replayed.
- space = !fifo_full && (fifo_count <= DEPTH-MARGIN). This is combinational from the inputs.
- States:
  - IDLE: if any req_valid, select the first set bit searching from rr_ptr+1 upward, with wrap. Next cycle: state=BURST, grant_id=winner, grant_valid=1, rr_ptr=winner, beat_cnt=0. If no request, remain in IDLE.
  - BURST: req_ready[grant_id] = space; all other ready bits are 0. A beat is accepted when req_valid[grant_id] && space; beat_cnt increments on each accepted beat.
  - BURST exits to IDLE (grant_valid=0 next cycle) on any of:
    - accepted beat with req_last=1;
    - accepted beat that makes beat_cnt==MAX_BURST;
    - req_valid[grant_id]==0 (producer stalls; grant released).
  - A stall caused by !space does not release the grant.
- Write stage: an accepted beat in cycle N gives fifo_wr_en=1 and fifo_din=that data in cycle N+1. Otherwise fifo_wr_en=0 and fifo_din holds its last value. Latency from accept to FIFO write is 1 cycle.
- Arbitration gap: one IDLE cycle between bursts. Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness: a producer that is continuously requesting is granted within NUM_REQ-1 other bursts.
- Non-granted producers see ready=0 and must hold valid and data. req_valid deasserting while not granted is legal.
- fifo_full asserted while fifo_count is low still blocks acceptance. space uses OR semantics, so either condition blocks.
- MAX_BURST=1: every accepted beat ends the grant.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST};
  - localparam ID_W=$clog2(NUM_REQ);
  - BEAT_W=$clog2(MAX_BURST+1).
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector, rr_ptr. Outputs: winner index, any flag.

Test Plan:
1. Reset, then req_valid=4'b0001, 3 beats 0xA1,0xA2,0xA3 with last on 0xA3 and fifo_count=0. Expected: grant_id=0 one cycle after valid; fifo_wr_en pulses carry A1,A2,A3 one cycle after each accept; grant_valid drops after the last beat.
2. All 4 producers stream without last, MAX_BURST=8. Expected: grants in order 0,1,2,3,0; each burst is exactly 8 beats; each burst is followed by a 1-cycle gap.
3. Producer 2 bursting; at beat 3 set fifo_count=61. Expected: req_ready[2]=0 and no fifo_wr_en until fifo_count<=60; grant is held; the burst resumes with beat 4 unchanged.
4. Producer 1 granted, deasserts valid after 2 beats while producer 3 is valid. Expected: grant released; after the IDLE cycle grant_id=3.
5. Assert rst for 1 cycle mid-burst (beat 5 of 8). Expected: all outputs go to their reset values immediately. After release with producers 0 and 3 both requesting, the first grant is to 0.
6. fifo_full=1 with fifo_count=10 during a burst. Expected: no accept and no write while full; acceptance resumes the cycle fifo_full falls.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared state type and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 8;
    localparam int ID_W          = $clog2(NUM_REQ_DEF);
    localparam int BEAT_W        = $clog2(MAX_BURST_DEF + 1);

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, with wrap.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_BITS-1:0] i_ptr,
    output logic [ID_BITS-1:0] o_winner,
    output logic               o_any
);

    logic [ID_BITS-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_BITS'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers,
// with a registered write stage and headroom-based throttling.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 8,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int MARGIN    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    input  logic [CNT_W-1:0]            fifo_count,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_din,
    output logic                        grant_valid,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id
);

    localparam int                GID_W       = idx_w(NUM_REQ);
    localparam int                BCNT_W      = idx_w(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  SPACE_LIMIT = CNT_W'(DEPTH - MARGIN);
    localparam logic [BCNT_W-1:0] BURST_LAST  = BCNT_W'(MAX_BURST);
    localparam logic [GID_W-1:0]  PTR_INIT    = GID_W'(NUM_REQ - 1);

    state_t              r_state, w_state_nxt;
    logic [GID_W-1:0]    r_grant_id, w_grant_id_nxt;
    logic [GID_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [GID_W-1:0]    w_winner;
    logic [BCNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt, w_beat_cnt_inc;
    logic                w_any, w_space, w_gvalid, w_glast, w_accept;
    logic [DATA_W-1:0]   w_gdata;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_din;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (GID_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Either a full flag or too little headroom blocks acceptance.
    assign w_space        = !fifo_full && (fifo_count <= SPACE_LIMIT);
    assign w_gvalid       = req_valid[r_grant_id];
    assign w_glast        = req_last[r_grant_id];
    assign w_accept       = (r_state == BURST) && w_gvalid && w_space;
    assign w_beat_cnt_inc = r_beat_cnt + BCNT_W'(1);

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GID_W'(i)) w_gdata = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == BURST) req_ready[r_grant_id] = w_space;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt    = BURST;
                    w_grant_id_nxt = w_winner;
                    w_rr_ptr_nxt   = w_winner;
                    w_beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                // A producer stall releases the grant; a space stall does not.
                if (!w_gvalid) begin
                    w_state_nxt = IDLE;
                end else if (w_space) begin
                    w_beat_cnt_nxt = w_beat_cnt_inc;
                    if (w_glast || (w_beat_cnt_inc == BURST_LAST)) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= PTR_INIT;
            r_beat_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_wr_en    <= w_accept;
            if (w_accept) r_din <= w_gdata;
        end
    end

    assign fifo_wr_en  = r_wr_en;
    assign fifo_din    = r_din;
    assign grant_valid = (r_state == BURST);
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against a per-cycle reference model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 64;
    localparam int CNT_W     = 8;
    localparam int MAX_BURST = 8;
    localparam int MARGIN    = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full = 1'b0;
    logic [CNT_W-1:0]          fifo_count = '0;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;
    logic                      grant_valid;
    logic [1:0]                grant_id;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    bit                 m_gv;
    int                 m_gid, m_ptr, m_cnt;
    bit                 m_wr;
    logic [DATA_W-1:0]  m_din;
    logic [NUM_REQ-1:0] m_ready;
    int                 last_acc_id;
    int                 grant_log[$];
    int                 burst_len[$];
    logic [DATA_W-1:0]  wr_log[$];

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .CNT_W(CNT_W), .MAX_BURST(MAX_BURST), .MARGIN(MARGIN)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    function automatic bit has_space();
        return !fifo_full && (int'(fifo_count) <= DEPTH - MARGIN);
    endfunction

    task automatic model_reset();
        m_gv = 0; m_gid = 0; m_ptr = NUM_REQ - 1; m_cnt = 0;
        m_wr = 0; m_din = '0; last_acc_id = -1;
        grant_log.delete(); burst_len.delete(); wr_log.delete();
    endtask

    // One clock: check outputs at negedge, advance the model, return at posedge+1.
    task automatic step();
        bit sp;
        int idx;
        @(negedge clk);
        sp = has_space();
        m_ready = '0;
        if (m_gv && sp) m_ready[m_gid] = 1'b1;
        chk("req_ready", req_ready, m_ready);
        chk("grant_valid", grant_valid, m_gv);
        if (m_gv) chk("grant_id", grant_id, m_gid);
        chk("fifo_wr_en", fifo_wr_en, m_wr);
        chk("fifo_din", fifo_din, m_din);
        if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_din);
        last_acc_id = -1;
        if (!m_gv) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (!m_gv && req_valid[idx]) begin
                    m_gv = 1; m_gid = idx; m_ptr = idx; m_cnt = 0;
                    grant_log.push_back(idx);
                end
            end
        end else if (!req_valid[m_gid]) begin
            m_gv = 0;
            burst_len.push_back(m_cnt);
        end else if (sp) begin
            last_acc_id = m_gid;
            m_din = req_data[m_gid*DATA_W +: DATA_W];
            m_cnt++;
            if (req_last[m_gid] || m_cnt == MAX_BURST) begin
                m_gv = 0;
                burst_len.push_back(m_cnt);
            end
        end
        m_wr = (last_acc_id >= 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_full = 1'b0; fifo_count = '0;
        model_reset();
    endtask

    initial begin
        int n;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        #2;

        // Test 1: single short packet from producer 0
        do_reset();
        req_valid = 4'b0001; set_data(0, 8'hA1);
        step();
        #1 chk("t1_grant_valid", grant_valid, 1);
        chk("t1_grant_id", grant_id, 0);
        step();
        set_data(0, 8'hA2); step();
        set_data(0, 8'hA3); req_last[0] = 1'b1; step();
        req_valid = '0; req_last = '0;
        #1 chk("t1_released", grant_valid, 0);
        step(); step();
        chk("t1_wr_count", wr_log.size(), 3);
        chk("t1_wr0", wr_log.size() > 0 ? wr_log[0] : 8'h00, 8'hA1);
        chk("t1_wr1", wr_log.size() > 1 ? wr_log[1] : 8'h00, 8'hA2);
        chk("t1_wr2", wr_log.size() > 2 ? wr_log[2] : 8'h00, 8'hA3);

        // Test 2: all producers stream without last
        do_reset();
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'($urandom));
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            step();
            if (last_acc_id >= 0) set_data(last_acc_id, 8'($urandom));
            n++;
        end
        req_valid = '0;
        step(); step();
        chk("t2_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t2_grant_order", i < grant_log.size() ? grant_log[i] : -1, exp_order[i]);
        for (int i = 0; i < 4; i++)
            chk("t2_burst_len", i < burst_len.size() ? burst_len[i] : -1, MAX_BURST);

        // Test 3: headroom stall on producer 2 after beat 3
        do_reset();
        req_valid = 4'b0100; set_data(2, 8'h41);
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            step();
            if (last_acc_id == 2) begin n++; set_data(2, 8'(8'h41 + n)); end
        end
        fifo_count = 8'd61;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t3_stall_ready", req_ready, 4'b0000);
            chk("t3_grant_held", grant_valid, 1);
            step();
        end
        chk("t3_no_write_while_stalled", wr_log.size(), 3);
        fifo_count = 8'd60;
        #1 chk("t3_resume_ready", req_ready, 4'b0100);
        step(); step();
        chk("t3_resume_count", wr_log.size(), 4);
        chk("t3_beat4_data", wr_log.size() > 3 ? wr_log[3] : 8'h00, 8'h44);
        req_valid = '0; step(); step();

        // Test 4: producer stall releases the grant
        do_reset();
        req_valid = 4'b0010; set_data(1, 8'h11); set_data(3, 8'h33);
        step();
        req_valid[3] = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            step();
            if (last_acc_id == 1) begin n++; set_data(1, 8'(8'h11 + n)); end
        end
        req_valid[1] = 1'b0;
        step();
        #1 chk("t4_released", grant_valid, 0);
        step();
        #1 chk("t4_next_grant_valid", grant_valid, 1);
        chk("t4_next_grant_id", grant_id, 3);
        req_valid = '0; step(); step();

        // Test 5: async reset mid-burst
        do_reset();
        req_valid = 4'b0010; set_data(1, 8'h50);
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            step();
            if (last_acc_id == 1) begin n++; set_data(1, 8'(8'h50 + n)); end
        end
        #2;
        do_reset();
        req_valid = 4'b1001; set_data(0, 8'h0A); set_data(3, 8'h3A);
        step();
        #1 chk("t5_first_grant_valid", grant_valid, 1);
        chk("t5_first_grant_id", grant_id, 0);
        req_valid = '0; step(); step();

        // Test 6: fifo_full blocks acceptance despite low occupancy
        do_reset();
        fifo_count = 8'd10;
        req_valid = 4'b0001; set_data(0, 8'h60);
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            step();
            if (last_acc_id == 0) begin n++; set_data(0, 8'(8'h60 + n)); end
        end
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t6_full_ready", req_ready, 4'b0000);
            step();
        end
        chk("t6_no_write_while_full", wr_log.size(), 2);
        fifo_full = 1'b0;
        #1 chk("t6_resume_ready", req_ready, 4'b0001);
        step(); step();
        chk("t6_resume_write", wr_log.size(), 3);
        req_valid = '0; step(); step();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            fifo_full  = ($urandom % 8) == 0;
            fifo_count = (($urandom % 4) == 0) ? 8'($urandom_range(55, 64)) : 8'($urandom_range(0, 54));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_acc_id == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom % 3) != 0;
                    set_data(i, 8'($urandom));
                    req_last[i] = ($urandom % 6) == 0;
                end else if (($urandom % 20) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
